// File: rtl/systolic_feeder.sv
// Transmit-side sequencer for the NxN systolic matrix-multiply array.
// Captures one A/B operand pair per job and drives the 2N-1 skewed a/b lanes
// as N diagonal wavefronts, each held HOLD cycles, then FLUSH_CYC zero cycles.
// Optional job counter: define SYSTOLIC_FEEDER_JOBCNT_EN to add job_cnt.
module systolic_feeder #(
  parameter int unsigned N         = 3,
  parameter int unsigned DW        = 8,
  parameter int unsigned HOLD      = 4,
  parameter int unsigned FLUSH_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*N*DW-1:0]       a_flat,
  input  logic [N*N*DW-1:0]       b_flat,
  input  logic                    abort,
  output logic [(2*N-1)*DW-1:0]   a_lane,
  output logic [(2*N-1)*DW-1:0]   b_lane,
  output logic                    lane_valid,
  output logic                    busy,
  output logic                    done
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
  ,
  output logic [15:0]             job_cnt
`endif
);

  localparam int unsigned LW     = (2 * N - 1) * DW;
  localparam int unsigned MW     = N * N * DW;
  localparam int unsigned WaveW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned HoldW  = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int unsigned FlushW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [WaveW-1:0]  WaveLast  = WaveW'(N - 1);
  localparam logic [HoldW-1:0]  HoldLast  = HoldW'(HOLD - 1);
  localparam logic [FlushW-1:0] FlushLast = FlushW'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

  typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDone} state_e;

  state_e            state_q;
  logic [WaveW-1:0]  wave_q;
  logic [HoldW-1:0]  hold_q;
  logic [FlushW-1:0] flush_q;
  logic [MW-1:0]     a_q;
  logic [MW-1:0]     b_q;

  // Wavefront k of A: row k of A lands on lanes k..k+N-1.
  function automatic logic [LW-1:0] a_wave(input logic [MW-1:0] m, input int k);
    logic [LW-1:0] r;
    r = '0;
    for (int j = 0; j < int'(N); j++) begin
      r[(k + j) * int'(DW) +: DW] = m[(k * int'(N) + j) * int'(DW) +: DW];
    end
    return r;
  endfunction

  // Wavefront k of B: column k of B lands on lanes k..k+N-1.
  function automatic logic [LW-1:0] b_wave(input logic [MW-1:0] m, input int k);
    logic [LW-1:0] r;
    r = '0;
    for (int j = 0; j < int'(N); j++) begin
      r[(k + j) * int'(DW) +: DW] = m[(j * int'(N) + k) * int'(DW) +: DW];
    end
    return r;
  endfunction

  // Job sequencer; every output is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wave_q     <= '0;
      hold_q     <= '0;
      flush_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      a_lane     <= '0;
      b_lane     <= '0;
      lane_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // in_ready is low for the first cycle out of reset, so gate on it.
          if (in_valid && in_ready) begin
            a_q        <= a_flat;
            b_q        <= b_flat;
            wave_q     <= '0;
            hold_q     <= '0;
            a_lane     <= a_wave(a_flat, 0);
            b_lane     <= b_wave(b_flat, 0);
            lane_valid <= 1'b1;
            busy       <= 1'b1;
            in_ready   <= 1'b0;
            state_q    <= StFeed;
          end else begin
            in_ready <= 1'b1;
          end
        end
        StFeed, StFlush: begin
          if (abort) begin
            state_q    <= StIdle;
            wave_q     <= '0;
            hold_q     <= '0;
            flush_q    <= '0;
            a_lane     <= '0;
            b_lane     <= '0;
            lane_valid <= 1'b0;
            busy       <= 1'b0;
            in_ready   <= 1'b1;
          end else if (state_q == StFeed) begin
            if (hold_q == HoldLast) begin
              hold_q <= '0;
              if (wave_q == WaveLast) begin
                wave_q <= '0;
                a_lane <= '0;
                b_lane <= '0;
                if (FLUSH_CYC == 0) begin
                  state_q    <= StDone;
                  done       <= 1'b1;
                  lane_valid <= 1'b0;
                  busy       <= 1'b0;
                end else begin
                  flush_q <= '0;
                  state_q <= StFlush;
                end
              end else begin
                wave_q <= wave_q + WaveW'(1);
                a_lane <= a_wave(a_q, int'(wave_q) + 1);
                b_lane <= b_wave(b_q, int'(wave_q) + 1);
              end
            end else begin
              hold_q <= hold_q + HoldW'(1);
            end
          end else begin
            if (flush_q == FlushLast) begin
              flush_q    <= '0;
              state_q    <= StDone;
              done       <= 1'b1;
              lane_valid <= 1'b0;
              busy       <= 1'b0;
            end else begin
              flush_q <= flush_q + FlushW'(1);
            end
          end
        end
        StDone: begin
          state_q  <= StIdle;
          in_ready <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
  // Completed-job counter, saturating; aborted jobs never raise done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_cnt <= '0;
    end else if (done && (job_cnt != 16'hFFFF)) begin
      job_cnt <= job_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder (default parameters).
module tb_systolic_feeder;

  localparam int N = 3;
  localparam int DW = 8;
  localparam int HOLD = 4;
  localparam int FLUSH = 16;
  localparam int LW = (2 * N - 1) * DW;
  localparam int MW = N * N * DW;
  localparam int JOBLEN = N * HOLD + FLUSH + 2;  // cycles until in_ready returns

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] a_flat;
  logic [MW-1:0] b_flat;
  logic          abort;
  logic [LW-1:0] a_lane;
  logic [LW-1:0] b_lane;
  logic          lane_valid;
  logic          busy;
  logic          done;
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
  logic [15:0]   job_cnt;
`endif

  systolic_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .abort      (abort),
    .a_lane     (a_lane),
    .b_lane     (b_lane),
    .lane_valid (lane_valid),
    .busy       (busy),
    .done       (done)
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    ,
    .job_cnt    (job_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_jobs = 0;

  typedef struct {
    int            cyc;
    logic [LW-1:0] a;
    logic [LW-1:0] b;
    logic          lv;
    logic          dn;
    logic          rdy;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [2*LW+3:0] act, input logic [2*LW+3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] p5(input logic [7:0] l0, input logic [7:0] l1,
                                       input logic [7:0] l2, input logic [7:0] l3,
                                       input logic [7:0] l4);
    return {l4, l3, l2, l1, l0};
  endfunction

  // Reference: expected outputs c cycles after the acceptance edge (c >= 1).
  function automatic logic [2*LW+3:0] model(input int c, input logic [MW-1:0] am,
                                             input logic [MW-1:0] bm);
    logic [LW-1:0] ea;
    logic [LW-1:0] eb;
    logic lv, bz, dn, rdy;
    ea = '0; eb = '0; lv = 0; bz = 0; dn = 0; rdy = 0;
    if (c >= 1 && c <= N * HOLD) begin
      int k;
      k = (c - 1) / HOLD;
      for (int j = 0; j < N; j++) begin
        ea[(k + j) * DW +: DW] = am[(k * N + j) * DW +: DW];
        eb[(k + j) * DW +: DW] = bm[(j * N + k) * DW +: DW];
      end
      lv = 1; bz = 1;
    end else if (c <= N * HOLD + FLUSH) begin
      lv = 1; bz = 1;
    end else if (c == N * HOLD + FLUSH + 1) begin
      dn = 1;
    end else begin
      rdy = 1;
    end
    return {ea, eb, lv, bz, dn, rdy};
  endfunction

  function automatic logic [2*LW+3:0] outs();
    return {a_lane, b_lane, lane_valid, busy, done, in_ready};
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] m;
    for (int e = 0; e < N * N; e++) m[e * DW +: DW] = 8'($urandom);
    return m;
  endfunction

  // Present a job and return just after the acceptance edge; inputs then go garbage.
  task automatic do_accept(input logic [MW-1:0] am, input logic [MW-1:0] bm, input logic ab);
    bit ok;
    ok = 0;
    a_flat = am; b_flat = bm; in_valid = 1'b1; abort = ab;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; abort = 1'b0; a_flat = '1; b_flat = '1;
  endtask

  task automatic run_job(input string name, input logic [MW-1:0] am, input logic [MW-1:0] bm,
                         input bit use_tbl);
    for (int c = 1; c <= JOBLEN; c++) begin
      @(negedge clk);
      chk(name, outs(), model(c, am, bm));
      if (use_tbl) begin
        for (int i = 0; i < 10; i++) begin
          if (tbl[i].cyc == c)
            chk($sformatf("vec_c%0d", c), outs(),
                {tbl[i].a, tbl[i].b, tbl[i].lv, tbl[i].lv, tbl[i].dn, tbl[i].rdy});
        end
      end
    end
    exp_jobs++;
  endtask

  logic [MW-1:0] am, bm;
  logic [LW-1:0] z;

  initial begin
    z = '0;
    tbl[0] = '{1,  p5(1, 2, 3, 0, 0), p5(9, 6, 3, 0, 0), 1, 0, 0};
    tbl[1] = '{4,  p5(1, 2, 3, 0, 0), p5(9, 6, 3, 0, 0), 1, 0, 0};
    tbl[2] = '{5,  p5(0, 4, 5, 6, 0), p5(0, 8, 5, 2, 0), 1, 0, 0};
    tbl[3] = '{8,  p5(0, 4, 5, 6, 0), p5(0, 8, 5, 2, 0), 1, 0, 0};
    tbl[4] = '{9,  p5(0, 0, 7, 8, 9), p5(0, 0, 7, 4, 1), 1, 0, 0};
    tbl[5] = '{12, p5(0, 0, 7, 8, 9), p5(0, 0, 7, 4, 1), 1, 0, 0};
    tbl[6] = '{13, z, z, 1, 0, 0};
    tbl[7] = '{28, z, z, 1, 0, 0};
    tbl[8] = '{29, z, z, 0, 1, 0};
    tbl[9] = '{30, z, z, 0, 0, 1};

    rst_n = 1'b1; in_valid = 1'b0; abort = 1'b0; a_flat = '0; b_flat = '0;
    #1 rst_n = 1'b0;
    #3 chk("reset_outputs", outs(), '0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) chk("ready_after_reset", outs(), model(JOBLEN, '0, '0));

    // Directed job A=1..9, B=9..1; inputs go to all-ones after acceptance.
    for (int e = 0; e < 9; e++) begin
      am[e * DW +: DW] = 8'(e + 1);
      bm[e * DW +: DW] = 8'(9 - e);
    end
    do_accept(am, bm, 1'b0);
    run_job("directed", am, bm, 1'b1);

    // Randomized jobs against the reference model.
    for (int r = 0; r < 4; r++) begin
      am = rand_mat(); bm = rand_mat();
      do_accept(am, bm, 1'b0);
      run_job($sformatf("rand%0d", r), am, bm, 1'b0);
    end

    // Abort sampled at the end of cycle t+6.
    am = rand_mat(); bm = rand_mat();
    do_accept(am, bm, 1'b0);
    for (int c = 1; c <= 6; c++) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk) chk("abort_idle", outs(), model(JOBLEN, '0, '0));
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (done) seen++;
      end
      chk("abort_no_done", 84'(seen), '0);
    end
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    chk("abort_jobcnt", 84'(job_cnt), 84'(exp_jobs));
`endif

    // Asynchronous reset mid-FEED, then a job presented with abort also high.
    am = rand_mat(); bm = rand_mat();
    do_accept(am, bm, 1'b0);
    for (int c = 1; c <= 6; c++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), '0);
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
    chk("async_reset_jobcnt", 84'(job_cnt), '0);
`endif
    exp_jobs = 0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) chk("ready_after_rerelease", outs(), model(JOBLEN, '0, '0));
    am = rand_mat(); bm = rand_mat();
    do_accept(am, bm, 1'b1);
    run_job("post_reset_abort_idle", am, bm, 1'b0);

    // in_valid held high: done pulses 30 cycles apart.
    begin
      int pulses[$];
      am = rand_mat(); bm = rand_mat();
      @(negedge clk);
      a_flat = am; b_flat = bm; in_valid = 1'b1;
      for (int c = 1; c <= 120; c++) begin
        @(negedge clk);
        if (done) begin
          pulses.push_back(c);
          if (pulses.size() == 3) begin
            in_valid = 1'b0;
            break;
          end
        end
      end
      chk("b2b_pulse_count", 84'(pulses.size()), 84'(3));
      if (pulses.size() == 3) begin
        chk("b2b_first_done", 84'(pulses[0]), 84'(N * HOLD + FLUSH + 1));
        chk("b2b_gap1", 84'(pulses[1] - pulses[0]), 84'(30));
        chk("b2b_gap2", 84'(pulses[2] - pulses[1]), 84'(30));
      end
      @(negedge clk);
`ifdef SYSTOLIC_FEEDER_JOBCNT_EN
      chk("b2b_jobcnt", 84'(job_cnt), 84'(exp_jobs + 3));
`endif
      chk("b2b_idle_after", outs(), model(JOBLEN, '0, '0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit-side sequencer for the 3x3 systolic matrix-multiply array.
- Accepts one operand pair (matrix A, matrix B) per job over a valid/ready handshake and captures it.
- Drives the array's 2N-1 skewed a/b input lanes as N diagonal wavefronts, each held HOLD cycles, then zero-flushes so the array drains.
- Signals completion with a one-cycle done pulse.

Parameters:
N, 3, matrix dimension; lane count is 2N-1.
DW, 8, operand element width.
HOLD, 4, cycles each wavefront is held on the lanes; HOLD >= 1.
FLUSH_CYC, 16, zero cycles driven after the last wavefront; FLUSH_CYC >= 0.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  feeder can accept a job.
a_flat  in  N*N*DW  A row-major; element e (0-based) at bits [e*DW +: DW].
b_flat  in  N*N*DW  B row-major, same packing as a_flat.
abort  in  1  synchronous job cancel.
a_lane  out  (2N-1)*DW  A lanes; lane L at bits [L*DW +: DW].
b_lane  out  (2N-1)*DW  B lanes, same packing as a_lane.
lane_valid  out  1  high while a wavefront or flush cycle is driven.
busy  out  1  high in FEED and FLUSH.
done  out  1  one-cycle job-complete pulse.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all counters 0; operand registers 0.
  - a_lane=0, b_lane=0, lane_valid=0, busy=0, done=0, in_ready=0 while rst_n is low.
  - in_ready rises the first cycle after rst_n deasserts.
- All outputs are registered; in_ready = (state==IDLE).
- States: IDLE, FEED, FLUSH, DONE.
- IDLE:
  - Lanes are 0.
  - On in_valid & in_ready at edge t: capture a_flat and b_flat into internal registers, set wave=0, hold=0, go to FEED.
  - Input values after t are don't-care.
- FEED:
  - Wavefront k (0..N-1) is driven during cycles t+1+k*HOLD through t+(k+1)*HOLD.
  - For j in 0..N-1: lane k+j carries a_lane = A[k][j] and b_lane = B[j][k].
  - All other lanes are 0.
  - The hold counter wraps at HOLD-1 and increments wave.
  - After wave N-1 completes: go to FLUSH, or directly to DONE if FLUSH_CYC == 0.
- FLUSH:
  - All lanes 0 for FLUSH_CYC cycles; lane_valid stays 1.
  - Then go to DONE.
- DONE:
  - done=1, lane_valid=0, busy=0, in_ready=0 for exactly one cycle.
  - Then return to IDLE.
  - done is therefore high in cycle t+1+N*HOLD+FLUSH_CYC.
- lane_valid = busy = 1 exactly in FEED and FLUSH.
- abort:
  - Sampled high in FEED or FLUSH: next cycle state=IDLE, lanes 0, counters cleared, no done pulse.
  - Ignored in IDLE and DONE.
  - abort and in_valid both high in IDLE: the job is accepted.
- in_valid while busy: not accepted (in_ready=0); the producer must hold it.
- Back-to-back jobs: earliest next acceptance is the cycle after DONE, i.e. minimum 2 cycles between jobs.
- No arithmetic is performed; values pass through unmodified at DW bits.
- Counter widths: $clog2 of the respective maximum, minimum 1.

Optional Feature:
- Macro: SYSTOLIC_FEEDER_JOBCNT_EN.
- Defined:
  - Adds output job_cnt [15:0], reset to 0.
  - Increments on each done pulse; saturates at 16'hFFFF.
  - Aborted jobs are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Defaults; A=1..9, B=9..1 (row-major); accept at t:
  - Cycles t+1..t+4: a lanes 0..4 = 1,2,3,0,0; b lanes = 9,6,3,0,0.
  - Cycles t+5..t+8: a lanes = 0,4,5,6,0; b lanes = 0,8,5,2,0.
  - Cycles t+9..t+12: a lanes = 0,0,7,8,9; b lanes = 0,0,7,4,1.
- Same job:
  - All lanes 0 with lane_valid=1 for t+13..t+28.
  - done=1 only at t+29; in_ready=1 again at t+30.
- Change a_flat and b_flat to 8'hFF one cycle after acceptance -> lane values are identical to the first scenario.
- abort high at t+6 -> IDLE and in_ready=1 at t+7, lanes 0, no done pulse.
  - With SYSTOLIC_FEEDER_JOBCNT_EN defined, job_cnt is unchanged.
- Drop rst_n asynchronously mid-FEED -> all outputs 0 immediately without a clock edge.
  - After release: in_ready=1, and a new job streams from wavefront 0.
- in_valid held high continuously -> jobs accepted every 30 cycles; done pulses 30 cycles apart.
  - With SYSTOLIC_FEEDER_JOBCNT_EN defined, job_cnt = 3 after three done pulses.
